// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage branch resolution and hazard control for the 5-stage MIPS pipeline.
// Selects forwarded branch operands, derives the number of stall cycles that
// forwarding cannot hide, sequences them with a RUN/STALL/FREEZE FSM and keeps
// saturating stall/taken counters.
module id_branch_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] MEM_RD_DATA_O_RS,
  input  logic [31:0] MEM_RD_DATA_O_RT,
  input  logic [31:0] WB_RD_DATA_O_RS,
  input  logic [31:0] WB_RD_DATA_O_RT,
  input  logic        FW_sig1_RS,
  input  logic        FW_sig1_RT,
  input  logic        FW_sig2_RS,
  input  logic        FW_sig2_RT,
  input  logic [4:0]  EX_RD,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  MEM_RD,
  input  logic        MEM_MemRead,
  input  logic        mem_busy,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] id_imm,
  output logic        stall,
  output logic        id_ex_bubble,
  output logic        if_flush,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic [15:0] stall_cnt,
  output logic [15:0] taken_cnt,
  output logic [1:0]  state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpSw    = 6'b101011;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StFreeze = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, taken_cnt_q;

  logic        is_beq, is_bne, is_branch, rt_used;
  logic [31:0] op_rs, op_rt;
  logic        taken;
  logic [1:0]  need_rs, need_rt, need;

  assign is_beq    = (opcode == OpBeq);
  assign is_bne    = (opcode == OpBne);
  assign is_branch = is_beq | is_bne;
  assign rt_used   = (opcode == OpRtype) | is_branch | (opcode == OpSw);

  // Stall cycles one source needs; register 0 never hazards.
  function automatic logic [1:0] src_need(input logic [4:0] src, input logic branch);
    logic ex_load, ex_alu, mem_load;
    ex_load  = EX_MemRead && (EX_RD == src);
    ex_alu   = EX_RegWrite && !EX_MemRead && (EX_RD == src);
    mem_load = MEM_MemRead && (MEM_RD == src);
    if (src == 5'd0) begin
      return 2'd0;
    end else if (branch) begin
      if (ex_load) return 2'd2;
      if (ex_alu || mem_load) return 2'd1;
      return 2'd0;
    end else begin
      return ex_load ? 2'd1 : 2'd0;
    end
  endfunction

  // Operand select (MEM forward beats WB forward) and hazard depth.
  always_comb begin
    op_rs = FW_sig1_RS ? MEM_RD_DATA_O_RS : (FW_sig2_RS ? WB_RD_DATA_O_RS : id_rs_data);
    op_rt = FW_sig1_RT ? MEM_RD_DATA_O_RT : (FW_sig2_RT ? WB_RD_DATA_O_RT : id_rt_data);
    taken = is_beq ? (op_rs == op_rt) : (is_bne && (op_rs != op_rt));
    need_rs = src_need(ID_RS, is_branch);
    need_rt = rt_used ? src_need(ID_RT, is_branch) : 2'd0;
    need    = (need_rs > need_rt) ? need_rs : need_rt;
  end

  assign branch_target = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};

  // Next-state and control outputs; all control is forced low during reset.
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;
    pc_src       = 1'b0;
    if (rst) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_busy) begin
            // Freeze wins over hazards and redirects; nothing is recorded.
            stall   = 1'b1;
            state_d = StFreeze;
          end else if (need != 2'd0) begin
            stall        = 1'b1;
            id_ex_bubble = 1'b1;
            if (need == 2'd2) state_d = StStall;
          end else if (taken) begin
            pc_src   = 1'b1;
            if_flush = 1'b1;
          end
        end
        StStall: begin
          stall        = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = mem_busy ? StFreeze : StRun;
        end
        StFreeze: begin
          stall = 1'b1;
          if (!mem_busy) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (id_ex_bubble && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (pc_src && (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign taken_cnt = taken_cnt_q;

endmodule
